wx_store_gate: RTL and testbench

- Store-path stage directly downstream of the LSU and upstream of the data-memory port.
- Buffers committed stores in a small FIFO.
- For each head store it drives the physical address to exec_ppn_tracker and applies the W^X decision (tracker hit, pre-lock override, sticky lock). Allowed stores are issued to memory; blocked stores are dropped and reported as faults.
- Replaces ad-hoc per-store gating with an ordered, handshaked pipeline.

---
 rtl/harvos_wx_pkg.sv | 15 +
 rtl/wx_store_fifo.sv | 48 ++++
 rtl/wx_store_gate.sv | 130 +++++++++++++
 tb/tb_wx_store_gate.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/harvos_wx_pkg.sv
// Shared definitions for the W^X store gate: page geometry, head FSM states
// and the fault counter width.
package harvos_wx_pkg;

  localparam int unsigned PAGE_SHIFT  = 12;
  localparam int unsigned FAULT_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    ISSUE,
    FAULT
  } state_t;

endpackage

// File: rtl/wx_store_fifo.sv
// Synchronous store FIFO with async reset. Pointers carry an extra wrap bit
// so full/empty/count fall straight out of the pointer pair.
module wx_store_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 68
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count   = wptr - rptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Payload storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/wx_store_gate.sv
// Ordered store gate: queues LSU stores, checks each head store against the
// executable-page tracker and the W^X lock, then issues or faults it.
module wx_store_gate
  import harvos_wx_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PPN_W  = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_data,
  input  logic [DATA_W/8-1:0]    req_strb,
  output logic [ADDR_W-1:0]      query_pa,
  input  logic                   hit_exec_ppn,
  input  logic                   exec_insert_i,
  input  logic [PPN_W-1:0]       exec_insert_ppn,
  input  logic                   lock_i,
  input  logic                   allow_override_prelock,
  output logic                   mem_valid,
  input  logic                   mem_ready,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_data,
  output logic [DATA_W/8-1:0]    mem_strb,
  output logic                   fault_valid,
  output logic [ADDR_W-1:0]      fault_addr,
  output logic [FAULT_CNT_W-1:0] fault_cnt,
  output logic                   locked_o
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned ENT_W  = ADDR_W + DATA_W + STRB_W;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

  state_t                 state;
  state_t                 state_next;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   empty;
  logic [CNT_W-1:0]       count;
  logic [ENT_W-1:0]       head;
  logic [ADDR_W-1:0]      head_addr;
  logic [DATA_W-1:0]      head_data;
  logic [STRB_W-1:0]      head_strb;
  logic                   more;
  logic                   override_on;
  logic                   exec_page;
  logic                   blocked;
  logic                   locked_q;
  logic [ADDR_W-1:0]      last_pa_q;
  logic [ADDR_W-1:0]      fault_addr_q;
  logic [FAULT_CNT_W-1:0] fault_cnt_q;

  wx_store_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ({req_addr, req_data, req_strb}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign {head_addr, head_data, head_strb} = head;

  assign req_ready = !full;
  assign push      = req_valid && req_ready;
  assign pop       = ((state == ISSUE) && mem_ready) || (state == FAULT);
  // Entries left after this pop, counting a same-cycle enqueue.
  assign more      = (count > CNT_W'(1)) || push;

  // A lock request in the checking cycle already kills the pre-lock override.
  assign override_on = allow_override_prelock && !locked_q && !lock_i;
  assign exec_page   = hit_exec_ppn ||
                       (exec_insert_i && (exec_insert_ppn == head_addr[ADDR_W-1:PAGE_SHIFT]));
  assign blocked     = exec_page && !override_on;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (!empty || push) state_next = CHECK;
      CHECK: state_next = blocked ? FAULT : ISSUE;
      ISSUE: if (mem_ready) state_next = more ? CHECK : IDLE;
      FAULT: state_next = more ? CHECK : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      locked_q     <= 1'b0;
      last_pa_q    <= '0;
      fault_addr_q <= '0;
      fault_cnt_q  <= '0;
    end else begin
      state    <= state_next;
      locked_q <= locked_q || lock_i;
      if (state == CHECK) begin
        last_pa_q <= head_addr;
        // Fault bookkeeping lands on entry to FAULT so it is visible with the pulse.
        if (blocked) begin
          fault_addr_q <= head_addr;
          if (fault_cnt_q != '1) fault_cnt_q <= fault_cnt_q + 1'b1;
        end
      end
    end
  end

  assign query_pa    = (state == CHECK) ? head_addr : last_pa_q;
  assign mem_valid   = (state == ISSUE);
  assign mem_addr    = head_addr;
  assign mem_data    = head_data;
  assign mem_strb    = head_strb;
  assign fault_valid = (state == FAULT);
  assign fault_addr  = fault_addr_q;
  assign fault_cnt   = fault_cnt_q;
  assign locked_o    = locked_q;

endmodule

// File: tb/tb_wx_store_gate.sv
// Randomised and directed bench for wx_store_gate, checked against a
// transaction-level model: an ordered queue of stores with their W^X verdicts.
module tb_wx_store_gate;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_strb;
  logic [31:0] query_pa;
  logic        hit_exec_ppn;
  logic        exec_insert_i;
  logic [19:0] exec_insert_ppn;
  logic        lock_i;
  logic        allow_override_prelock;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [3:0]  mem_strb;
  logic        fault_valid;
  logic [31:0] fault_addr;
  logic [15:0] fault_cnt;
  logic        locked_o;

  always #5 clk = ~clk;

  wx_store_gate #(
    .DEPTH  (4),
    .ADDR_W (32),
    .DATA_W (32),
    .PPN_W  (20)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .req_valid              (req_valid),
    .req_ready              (req_ready),
    .req_addr               (req_addr),
    .req_data               (req_data),
    .req_strb               (req_strb),
    .query_pa               (query_pa),
    .hit_exec_ppn           (hit_exec_ppn),
    .exec_insert_i          (exec_insert_i),
    .exec_insert_ppn        (exec_insert_ppn),
    .lock_i                 (lock_i),
    .allow_override_prelock (allow_override_prelock),
    .mem_valid              (mem_valid),
    .mem_ready              (mem_ready),
    .mem_addr               (mem_addr),
    .mem_data               (mem_data),
    .mem_strb               (mem_strb),
    .fault_valid            (fault_valid),
    .fault_addr             (fault_addr),
    .fault_cnt              (fault_cnt),
    .locked_o               (locked_o)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference tracker: a small set of executable pages.
  logic [19:0] trk   [4];
  bit          trk_v [4];
  bit          m_locked;
  int          m_faults;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    bit          blk;
  } st_t;
  st_t expq[$];

  always_comb begin
    hit_exec_ppn = 1'b0;
    for (int i = 0; i < 4; i++)
      if (trk_v[i] && trk[i] == query_pa[31:12]) hit_exec_ppn = 1'b1;
  end

  function automatic bit in_trk(input logic [19:0] ppn);
    for (int i = 0; i < 4; i++)
      if (trk_v[i] && trk[i] == ppn) return 1'b1;
    return 1'b0;
  endfunction

  task automatic trk_add(input logic [19:0] ppn);
    for (int i = 0; i < 4; i++)
      if (!trk_v[i]) begin
        trk[i]   = ppn;
        trk_v[i] = 1'b1;
        return;
      end
  endtask

  // Observed side: every issue and fault must match the oldest expected store.
  always @(negedge clk) begin
    st_t e;
    if (rst_n) begin
      if (mem_valid && mem_ready) begin
        if (expq.size() == 0) check_eq("issue_unexpected", mem_valid, 1'b0);
        else begin
          e = expq.pop_front();
          check_eq("issue_allowed", e.blk, 1'b0);
          check_eq("issue_addr", mem_addr, e.addr);
          check_eq("issue_data", mem_data, e.data);
          check_eq("issue_strb", mem_strb, e.strb);
        end
      end
      if (fault_valid) begin
        if (expq.size() == 0) check_eq("fault_unexpected", fault_valid, 1'b0);
        else begin
          e = expq.pop_front();
          if (m_faults < 16'hFFFF) m_faults++;
          check_eq("fault_blocked", e.blk, 1'b1);
          check_eq("fault_addr", fault_addr, e.addr);
          check_eq("fault_cnt", fault_cnt, m_faults);
        end
      end
    end
  end

  // forced < 0: verdict from tracker/lock model at acceptance; else forced verdict.
  task automatic push_store(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int forced);
    st_t e;
    int  n;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_strb  = s;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check_eq("push_timeout", req_ready, 1'b1);
      req_valid = 1'b0;
      return;
    end
    e.addr = a;
    e.data = d;
    e.strb = s;
    if (forced >= 0) e.blk = (forced != 0);
    else e.blk = in_trk(a[31:12]) && !(allow_override_prelock && !m_locked && !lock_i);
    expq.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", expq.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bit          done;
    logic [19:0] pages [4];
    logic [31:0] a;
    int          n;

    pages[0] = 20'h08004; pages[1] = 20'h08005;
    pages[2] = 20'h09003; pages[3] = 20'h0900A;
    for (int i = 0; i < 4; i++) trk_v[i] = 1'b0;
    m_locked = 1'b0;
    m_faults = 0;
    rst_n = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_data = '0; req_strb = '0;
    exec_insert_i = 1'b0; exec_insert_ppn = '0;
    lock_i = 1'b0; allow_override_prelock = 1'b0; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check_eq("rst_req_ready", req_ready, 1'b1);
    check_eq("rst_mem_valid", mem_valid, 1'b0);
    check_eq("rst_fault_valid", fault_valid, 1'b0);
    check_eq("rst_fault_addr", fault_addr, 32'h0);
    check_eq("rst_fault_cnt", fault_cnt, 16'h0);
    check_eq("rst_locked", locked_o, 1'b0);
    check_eq("rst_query_pa", query_pa, 32'h0);

    // Best-case latency: CHECK in t+1, mem_valid in t+2.
    push_store(32'h0800_4000, 32'hDEAD_BEEF, 4'hF, -1);
    @(negedge clk);
    check_eq("lat_check_pa", query_pa, 32'h0800_4000);
    check_eq("lat_check_novalid", mem_valid, 1'b0);
    @(negedge clk);
    check_eq("lat_issue_valid", mem_valid, 1'b1);
    check_eq("lat_issue_addr", mem_addr, 32'h0800_4000);
    check_eq("lat_issue_data", mem_data, 32'hDEAD_BEEF);
    wait_drain();
    check_eq("lat_query_hold", query_pa, 32'h0800_4000);

    // Tracked page -> fault.
    trk_add(20'h08004);
    push_store(32'h0800_4010, 32'h1111_2222, 4'h3, -1);
    wait_drain();
    check_eq("trk_fault_cnt", fault_cnt, 16'd1);
    check_eq("trk_fault_addr_held", fault_addr, 32'h0800_4010);

    // Pre-lock override, then lock.
    allow_override_prelock = 1'b1;
    push_store(32'h0800_4020, 32'h3333_4444, 4'hF, -1);
    wait_drain();
    @(posedge clk); #1 lock_i = 1'b1; m_locked = 1'b1;
    @(posedge clk); #1 lock_i = 1'b0;
    @(negedge clk);
    check_eq("lock_set", locked_o, 1'b1);
    push_store(32'h0800_4030, 32'h5555_6666, 4'hF, -1);
    wait_drain();
    check_eq("lock_sticky", locked_o, 1'b1);
    allow_override_prelock = 1'b0;

    // Fill with memory stalled; blocked store in position 2.
    mem_ready = 1'b0;
    push_store(32'h0900_0000, 32'hA000_0001, 4'h1, -1);
    push_store(32'h0800_4040, 32'hA000_0002, 4'h2, -1);
    push_store(32'h0900_1000, 32'hA000_0003, 4'h4, -1);
    push_store(32'h0900_2000, 32'hA000_0004, 4'h8, -1);
    @(negedge clk);
    check_eq("fill_not_ready", req_ready, 1'b0);
    mem_ready = 1'b1;
    wait_drain();
    check_eq("fill_ready_again", req_ready, 1'b1);

    // Insert snoop coincident with CHECK.
    push_store(32'h0800_5000, 32'hBBBB_CCCC, 4'hF, 1);
    exec_insert_i = 1'b1; exec_insert_ppn = 20'h08005;
    @(posedge clk); #1;
    exec_insert_i = 1'b0;
    trk_add(20'h08005);
    wait_drain();

    // Random traffic with random memory back-pressure.
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          a = {pages[$urandom_range(0, 3)], 12'h000};
          a[11:2] = 10'($urandom);
          push_store(a, $urandom, 4'($urandom), -1);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          mem_ready = 1'($urandom);
        end
        mem_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset during a stalled ISSUE.
    mem_ready = 1'b0;
    push_store(32'h0900_4000, 32'h7777_8888, 4'hF, -1);
    n = 0;
    while (!mem_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("rst_pre_valid", mem_valid, 1'b1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check_eq("rst_mid_valid", mem_valid, 1'b0);
    expq.delete();
    m_faults = 0;
    m_locked = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst2_req_ready", req_ready, 1'b1);
    check_eq("rst2_fault_cnt", fault_cnt, 16'h0);
    check_eq("rst2_locked", locked_o, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check_eq("rst2_empty_novalid", mem_valid, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
